// File: rtl/amp_pkg.sv
// Shared types and helpers for the amplitude vector operator.
//   mode_e  : operation select (pass / bitwise not / negate / conjugate)
//   state_e : sequencer states
//   sat_neg : saturating two's-complement negate of a w-bit value
//   neg_ovf : flags the one input that sat_neg has to clamp
// Values are carried sign-extended in MaxW bits so one function serves any W < MaxW.
package amp_pkg;

  localparam int unsigned MaxW = 64;

  typedef enum logic [1:0] {
    ModePass = 2'd0,
    ModeNot  = 2'd1,
    ModeNeg  = 2'd2,
    ModeConj = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Most negative w-bit value, sign-extended to MaxW bits.
  function automatic logic [MaxW-1:0] min_val(input int unsigned w);
    logic [MaxW-1:0] m;
    m = '1;
    return m << (w - 1);
  endfunction

  // -x, except the most negative value (which has no positive twin) clamps to the maximum.
  function automatic logic [MaxW-1:0] sat_neg(input logic [MaxW-1:0] x, input int unsigned w);
    if (x == min_val(w)) return ~min_val(w);
    return '0 - x;
  endfunction

  function automatic logic neg_ovf(input logic [MaxW-1:0] x, input int unsigned w);
    return x == min_val(w);
  endfunction

endpackage

// File: rtl/amp_lane.sv
// One-amplitude combinational datapath.
//   i_amp  : {re, im}, each W-bit signed
//   i_mode : operation select
//   o_res  : result amplitude, same packing
//   o_sat  : a negation had to saturate (only possible in NEG / CONJ)
module amp_lane
  import amp_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [2*W-1:0] i_amp,
  input  mode_e          i_mode,
  output logic [2*W-1:0] o_res,
  output logic           o_sat
);

  logic [W-1:0]    w_re;
  logic [W-1:0]    w_im;
  logic [MaxW-1:0] w_re_ext;
  logic [MaxW-1:0] w_im_ext;
  logic [W-1:0]    w_re_neg;
  logic [W-1:0]    w_im_neg;
  logic            w_re_ovf;
  logic            w_im_ovf;

  assign w_re     = i_amp[2*W-1:W];
  assign w_im     = i_amp[W-1:0];
  assign w_re_ext = MaxW'($signed(w_re));
  assign w_im_ext = MaxW'($signed(w_im));
  assign w_re_neg = W'(sat_neg(w_re_ext, W));
  assign w_im_neg = W'(sat_neg(w_im_ext, W));
  assign w_re_ovf = neg_ovf(w_re_ext, W);
  assign w_im_ovf = neg_ovf(w_im_ext, W);

  always_comb begin
    o_res = i_amp;
    o_sat = 1'b0;
    unique case (i_mode)
      ModePass: o_res = i_amp;
      ModeNot:  o_res = ~i_amp;
      ModeNeg: begin
        o_res = {w_re_neg, w_im_neg};
        o_sat = w_re_ovf | w_im_ovf;
      end
      ModeConj: begin
        o_res = {w_re, w_im_neg};
        o_sat = w_im_ovf;
      end
      default: o_res = i_amp;
    endcase
  end

endmodule

// File: rtl/amp_vec_op.sv
// Element-wise operator over a packed 2**N-amplitude state vector, P amplitudes per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle request, honoured only in idle
//   mode       : 0 pass, 1 not, 2 neg, 3 conj
//   vec_in     : amplitude k at [k*2W +: 2W], {re, im}
//   vec_out    : result vector, same packing; untouched amplitudes keep old values
//   busy       : high from the cycle after start through the done cycle
//   done       : one-cycle pulse once every beat has been written
//   sat        : sticky saturation flag, cleared by the next accepted start
module amp_vec_op
  import amp_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2,
  parameter int unsigned P = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [(2**N)*2*W-1:0]  vec_in,
  output logic [(2**N)*2*W-1:0]  vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   sat
);

  localparam int unsigned Amps  = 2 ** N;
  localparam int unsigned AW    = 2 * W;
  localparam int unsigned Beats = Amps / P;
  localparam int unsigned BW    = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned IdxW  = (Amps > 1) ? $clog2(Amps) : 1;
  localparam logic [BW-1:0] LastBeat = BW'(Beats - 1);

  state_e                   r_state;
  logic [BW-1:0]            r_beat;
  mode_e                    r_mode;
  logic [Amps-1:0][AW-1:0]  r_vec_in;
  logic [Amps-1:0][AW-1:0]  r_vec_out;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_sat;

  logic [P-1:0][IdxW-1:0]   w_idx;
  logic [P-1:0][AW-1:0]     w_lane_in;
  logic [P-1:0][AW-1:0]     w_lane_out;
  logic [P-1:0]             w_lane_sat;

  // Lane p of beat b handles amplitude b*P + p.
  always_comb begin
    for (int unsigned p = 0; p < P; p++) begin
      w_idx[p]     = IdxW'(32'(r_beat) * P + p);
      w_lane_in[p] = r_vec_in[w_idx[p]];
    end
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    amp_lane #(
      .W(W)
    ) u_lane (
      .i_amp  (w_lane_in[g]),
      .i_mode (r_mode),
      .o_res  (w_lane_out[g]),
      .o_sat  (w_lane_sat[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_beat    <= '0;
      r_mode    <= ModePass;
      r_vec_in  <= '0;
      r_vec_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state  <= StRun;
            r_mode   <= mode_e'(mode);
            r_vec_in <= vec_in;
            r_beat   <= '0;
            r_sat    <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        StRun: begin
          for (int unsigned p = 0; p < P; p++) begin
            r_vec_out[w_idx[p]] <= w_lane_out[p];
          end
          if (|w_lane_sat) r_sat <= 1'b1;
          if (r_beat == LastBeat) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign vec_out = r_vec_out;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sat     = r_sat;

endmodule

// File: doc/amp_vec_op.md
AMP_VEC_OP -- requirements
Module: amp_vec_op

Interface
REQ-001 The block SHALL provide parameter N, default 3, which sets the qubit count; the state vector holds 2**N amplitudes.
REQ-002 The block SHALL provide parameter W, default 2, which sets the signed width of each real and imaginary component.
REQ-003 The block SHALL provide parameter P, default 2, which sets the lanes (amplitudes) processed per cycle; P SHALL be a power of two and SHALL divide 2**N.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin an operation.
REQ-007 mode  input  2  operation select: 0 PASS, 1 NOT, 2 NEG, 3 CONJ.
REQ-008 vec_in  input  2**N*2*W  packed state vector; amplitude k at bits [k*2W +: 2W], real in upper W bits, imag in lower W bits.
REQ-009 vec_out  output  2**N*2*W  result vector, same packing as vec_in.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when vec_out is complete.
REQ-012 sat  output  1  sticky flag; set if any saturation occurred in the current or last operation.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE->RUN SHALL occur on start=1; on that edge vec_in and mode SHALL be latched into internal registers, the beat counter SHALL clear, and sat SHALL clear.
REQ-015 In RUN, each cycle SHALL process amplitudes beat*P .. beat*P+P-1 of the latched vector, write them into vec_out, and increment beat.
REQ-016 RUN->DONE SHALL occur after beat 2**N/P-1 is written; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency SHALL be 2**N/P+1 cycles from the start edge to the done pulse.
REQ-018 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-019 start SHALL be ignored while busy=1; latched inputs SHALL NOT change mid-operation.
REQ-020 start asserted in the DONE cycle SHALL be ignored; a new start is accepted from IDLE only.
REQ-021 PASS SHALL copy each amplitude unchanged.
REQ-022 NOT SHALL produce the bitwise inverse of all 2W bits.
REQ-023 NEG SHALL negate both real and imaginary components as two's complement, saturating -2**(W-1) to 2**(W-1)-1.
REQ-024 CONJ SHALL negate the imaginary component only, with the same saturation, and SHALL pass the real component unchanged.
REQ-025 sat SHALL be set on any saturation event in NEG or CONJ, and SHALL hold until the next accepted start.
REQ-026 Amplitudes not yet processed in the current operation SHALL retain their previous vec_out values; vec_out SHALL be stable from done until the next accepted start.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, and SHALL zero vec_out, busy, done, sat, the beat counter and the latched registers.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL be in IDLE and accept start.

Structure
REQ-029 A shared package amp_pkg SHALL hold the mode enum (PASS, NOT, NEG, CONJ), the FSM state enum, and a function for the saturating negate of a W-bit value.
REQ-030 The per-amplitude datapath SHALL be a combinational sub-module amp_lane (inputs: one amplitude and mode; outputs: result and saturation bit), instantiated P times through generate.
REQ-031 The beat counter width SHALL be $clog2(2**N/P), with a minimum of 1.

Verification (N=3, W=2, P=2 unless stated)
REQ-032 Scenario 1: PASS, vec_in=32'h1234_5678, start -> done exactly 5 cycles after the start edge, vec_out=32'h1234_5678, sat=0.
REQ-033 Scenario 2: NOT, vec_in=32'h0F0F_A5A5 -> vec_out=32'hF0F0_5A5A, busy high for 5 cycles.
REQ-034 Scenario 3: NEG, all amplitudes 4'b1001 (re=-2, im=1) -> each amplitude 4'b0111 (re=+1 saturated, im=-1), sat=1.
REQ-035 Scenario 4: CONJ, all amplitudes 4'b0110 (re=1, im=-2) -> each amplitude 4'b0101, sat=1; a following PASS run clears sat to 0.
REQ-036 Scenario 5: start and a changed vec_in/mode applied during RUN -> ignored, result matches the first request, single done pulse.
REQ-037 Scenario 6: rst_n low at beat 2 of a NOT run -> vec_out=0, busy=0, no done pulse; the next start completes normally (repeat with P=8: latency 2 cycles).
